// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max/average pooling over a raster pixel stream.
// in: clk, rst_n, in_data/in_valid/in_sof; out: out_data/out_valid/out_last.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 3,
  parameter int IMG_W      = 26,
  parameter int IMG_H      = 26,
  parameter int SIGNED     = 0,
  parameter int MODE       = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  input  logic                           in_sof,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  output logic                           out_last
);

  localparam int DW  = DATA_WIDTH;
  localparam int HW  = DW + MODE;
  localparam int SW  = DW + 2;
  localparam int PW  = CHANNELS * DW;
  localparam int LBW = CHANNELS * HW;
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int LBN = IMG_W / 2;
  localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

  localparam logic [XW-1:0] X_END = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_END = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_OUT = XW'(2 * (IMG_W / 2) - 1);
  localparam logic [YW-1:0] Y_OUT = YW'(2 * (IMG_H / 2) - 1);

  // All arithmetic runs in SW-bit signed space; unsigned
  // samples are zero-extended so one signed compare serves both.
  function automatic logic signed [SW-1:0] ext_d(
    input logic [DW-1:0] s
  );
    if (SIGNED != 0) return SW'($signed(s));
    else             return SW'(s);
  endfunction

  function automatic logic signed [SW-1:0] ext_h(
    input logic [HW-1:0] s
  );
    if (SIGNED != 0) return SW'($signed(s));
    else             return SW'(s);
  endfunction

  function automatic logic signed [SW-1:0] max2(
    input logic signed [SW-1:0] a,
    input logic signed [SW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;
  logic [PW-1:0] hold_q, hold_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic [LBW-1:0] lb_q [LBN];
  logic [LBW-1:0] lb_wdata;
  logic [LBW-1:0] lb_rd;
  logic [LW-1:0]  lb_idx;
  logic           lb_we;

  logic signed [SW-1:0] a_e [CHANNELS];
  logic signed [SW-1:0] b_e [CHANNELS];
  logic signed [SW-1:0] l_e [CHANNELS];
  logic signed [SW-1:0] h_e [CHANNELS];
  logic signed [SW-1:0] v_e [CHANNELS];
  logic [PW-1:0]        pool;
  logic                 unused_bits;

  always_comb begin
    // A valid sof beat restarts the frame at (0,0).
    x_cur       = (in_valid && in_sof) ? '0 : x_q;
    y_cur       = (in_valid && in_sof) ? '0 : y_q;
    x_d         = x_q;
    y_d         = y_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    lb_we       = 1'b0;
    lb_idx      = LW'(x_cur >> 1);
    lb_rd       = lb_q[lb_idx];
    lb_wdata    = '0;
    pool        = '0;
    unused_bits = 1'b0;

    for (int c = 0; c < CHANNELS; c++) begin
      a_e[c] = ext_d(hold_q[c*DW +: DW]);
      b_e[c] = ext_d(in_data[c*DW +: DW]);
      l_e[c] = ext_h(lb_rd[c*HW +: HW]);
      h_e[c] = (MODE != 0) ? a_e[c] + b_e[c]
                           : max2(a_e[c], b_e[c]);
      v_e[c] = (MODE != 0) ? l_e[c] + h_e[c]
                           : max2(l_e[c], h_e[c]);
      lb_wdata[c*HW +: HW] = h_e[c][HW-1:0];
      // Dropping the two LSBs of the 4-sum floors it.
      pool[c*DW +: DW] = (MODE != 0) ? v_e[c][DW+1:2]
                                     : v_e[c][DW-1:0];
      unused_bits = unused_bits ^ (^v_e[c]) ^ (^h_e[c]);
    end

    if (in_valid) begin
      if (x_cur == X_END) begin
        x_d = '0;
        y_d = (y_cur == Y_END) ? '0 : y_cur + 1'b1;
      end else begin
        x_d = x_cur + 1'b1;
        y_d = y_cur;
      end
      // Odd x and odd y are always inside the pooled area,
      // so a trailing odd column/row never reaches here.
      if (!x_cur[0]) begin
        hold_d = in_data;
      end else if (!y_cur[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = pool;
        out_last_d  = (x_cur == X_OUT) && (y_cur == Y_OUT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Even rows write, odd rows read: never the same cycle.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[lb_idx] <= lb_wdata;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: four 4x4 variants (max/avg,
// unsigned/signed) share one stream; a 5x5 max variant has its own.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]      d4 = '0;
  logic             v4 = 1'b0;
  logic             s4 = 1'b0;
  logic [3:0][15:0] od;
  logic [3:0]       ov;
  logic [3:0]       ol;

  logic [15:0] d5 = '0;
  logic        v5 = 1'b0;
  logic        s5 = 1'b0;
  logic [15:0] od5;
  logic        ov5;
  logic        ol5;

  maxpool2x2_stream #(.DATA_WIDTH(8), .CHANNELS(2),
    .IMG_W(4), .IMG_H(4), .SIGNED(0), .MODE(0)) u_mu (
    .clk(clk), .rst_n(rst_n), .in_data(d4),
    .in_valid(v4), .in_sof(s4), .out_data(od[0]),
    .out_valid(ov[0]), .out_last(ol[0]));

  maxpool2x2_stream #(.DATA_WIDTH(8), .CHANNELS(2),
    .IMG_W(4), .IMG_H(4), .SIGNED(1), .MODE(0)) u_ms (
    .clk(clk), .rst_n(rst_n), .in_data(d4),
    .in_valid(v4), .in_sof(s4), .out_data(od[1]),
    .out_valid(ov[1]), .out_last(ol[1]));

  maxpool2x2_stream #(.DATA_WIDTH(8), .CHANNELS(2),
    .IMG_W(4), .IMG_H(4), .SIGNED(0), .MODE(1)) u_au (
    .clk(clk), .rst_n(rst_n), .in_data(d4),
    .in_valid(v4), .in_sof(s4), .out_data(od[2]),
    .out_valid(ov[2]), .out_last(ol[2]));

  maxpool2x2_stream #(.DATA_WIDTH(8), .CHANNELS(2),
    .IMG_W(4), .IMG_H(4), .SIGNED(1), .MODE(1)) u_as (
    .clk(clk), .rst_n(rst_n), .in_data(d4),
    .in_valid(v4), .in_sof(s4), .out_data(od[3]),
    .out_valid(ov[3]), .out_last(ol[3]));

  maxpool2x2_stream #(.DATA_WIDTH(8), .CHANNELS(2),
    .IMG_W(5), .IMG_H(5), .SIGNED(0), .MODE(0)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_data(d5),
    .in_valid(v5), .in_sof(s5), .out_data(od5),
    .out_valid(ov5), .out_last(ol5));

  int errors = 0;
  int checks = 0;

  // Reference: whole-image store per group, pooled on demand.
  int          gw [2] = '{4, 5};
  int          gh [2] = '{4, 5};
  int          mx [2] = '{0, 0};
  int          my [2] = '{0, 0};
  logic [15:0] pix [2][8][8];
  logic        ev [2] = '{1'b0, 1'b0};
  logic        el [2] = '{1'b0, 1'b0};
  logic [15:0] ed [5] = '{default: '0};

  logic        collect = 1'b0;
  logic [15:0] q0 [$];
  int          n5 = 0;

  typedef struct {
    logic [7:0] a, b, c, d;
    logic [7:0] e0, e1, e2, e3;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [7:0] ref_pool(
    input int mode, input int sgn,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [7:0] d
  );
    logic [7:0] s [4];
    int v [4];
    int r;
    s = '{a, b, c, d};
    for (int i = 0; i < 4; i++)
      v[i] = (sgn != 0) ? int'($signed(s[i])) : int'(s[i]);
    if (mode == 0) begin
      r = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > r) r = v[i];
    end else begin
      r = (v[0] + v[1] + v[2] + v[3]) >>> 2;
    end
    return r[7:0];
  endfunction

  task automatic step(input int g, input logic v,
                      input logic sof, input logic [15:0] data);
    int x, y;
    ev[g] = 1'b0;
    el[g] = 1'b0;
    if (v) begin
      if (sof) begin
        mx[g] = 0;
        my[g] = 0;
      end
      x = mx[g];
      y = my[g];
      pix[g][y][x] = data;
      if (x % 2 == 1 && y % 2 == 1 &&
          x < 2 * (gw[g] / 2) && y < 2 * (gh[g] / 2)) begin
        ev[g] = 1'b1;
        el[g] = (x == 2 * (gw[g] / 2) - 1) &&
                (y == 2 * (gh[g] / 2) - 1);
        for (int k = 0; k < 5; k++) begin
          if ((k < 4) == (g == 0)) begin
            for (int ch = 0; ch < 2; ch++)
              ed[k][ch*8 +: 8] = ref_pool(
                (k < 4) ? k >> 1 : 0, (k < 4) ? k & 1 : 0,
                pix[g][y-1][x-1][ch*8 +: 8],
                pix[g][y-1][x][ch*8 +: 8],
                pix[g][y][x-1][ch*8 +: 8],
                pix[g][y][x][ch*8 +: 8]);
          end
        end
      end
      mx[g] = x + 1;
      if (mx[g] == gw[g]) begin
        mx[g] = 0;
        my[g] = (y + 1 == gh[g]) ? 0 : y + 1;
      end
    end
  endtask

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("valid%0d", k), 16'(ov[k]), 16'(ev[0]));
      check($sformatf("last%0d", k), 16'(ol[k]), 16'(el[0]));
      check($sformatf("data%0d", k), od[k], ed[k]);
    end
    check("valid_odd", 16'(ov5), 16'(ev[1]));
    check("last_odd", 16'(ol5), 16'(el[1]));
    check("data_odd", od5, ed[4]);
  endtask

  task automatic cyc(input logic va, input logic sa,
                     input logic [15:0] da, input logic vb,
                     input logic sb, input logic [15:0] db);
    v4 = va; s4 = sa; d4 = da;
    v5 = vb; s5 = sb; d5 = db;
    @(posedge clk);
    #1;
    step(0, va, sa, da);
    step(1, vb, sb, db);
    compare_all();
    if (collect && ov[0]) q0.push_back(od[0]);
    if (ov5) n5++;
  endtask

  task automatic beat4(input logic sof, input logic [15:0] d);
    cyc(1'b1, sof, d, 1'b0, 1'b0, '0);
  endtask

  initial begin
    tbl[0] = '{8'h80, 8'hFF, 8'h90, 8'h85,
               8'hFF, 8'hFF, 8'hA5, 8'hA5};
    tbl[1] = '{8'h7F, 8'h80, 8'h01, 8'h00,
               8'h80, 8'h7F, 8'h40, 8'h00};
    tbl[2] = '{8'h01, 8'h02, 8'h03, 8'h05,
               8'h05, 8'h05, 8'h02, 8'h02};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE,
               8'hFF, 8'hFF, 8'hFE, 8'hFE};
    tbl[4] = '{8'h80, 8'h80, 8'h80, 8'h81,
               8'h81, 8'h81, 8'h80, 8'h80};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};

    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Raster ramp, ch1 mirrored.
    collect = 1'b1;
    for (int i = 0; i < 16; i++)
      beat4(i == 0, {8'(15 - i), 8'(i)});
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    collect = 1'b0;
    check("ramp_count", 16'(q0.size()), 16'd4);
    if (q0.size() == 4) begin
      check("ramp_o0", q0[0], {8'd15, 8'd5});
      check("ramp_o1", q0[1], {8'd13, 8'd7});
      check("ramp_o2", q0[2], {8'd7, 8'd13});
      check("ramp_o3", q0[3], {8'd5, 8'd15});
    end

    // Constant blocks tiled over a whole frame.
    foreach (tbl[i]) begin
      logic [7:0] ex [4];
      logic [7:0] px;
      ex = '{tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3};
      for (int p = 0; p < 16; p++) begin
        case ((p / 4) % 2 * 2 + p % 2)
          0: px = tbl[i].a;
          1: px = tbl[i].b;
          2: px = tbl[i].c;
          default: px = tbl[i].d;
        endcase
        beat4(p == 0, {px, px});
      end
      for (int k = 0; k < 4; k++)
        check($sformatf("tbl%0d_k%0d", i, k), od[k],
              {ex[k], ex[k]});
    end

    // Resync: abort after 5 beats.
    for (int i = 0; i < 5; i++)
      beat4(i == 0, 16'($urandom));
    for (int i = 0; i < 16; i++)
      beat4(i == 0, 16'($urandom));

    // Async reset right after an output pulse.
    for (int i = 0; i < 6; i++)
      beat4(i == 0, 16'($urandom));
    v4 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 16'(ov), 16'd0);
    check("rst_async_last", 16'(ol), 16'd0);
    mx = '{0, 0};
    my = '{0, 0};
    ev = '{1'b0, 1'b0};
    el = '{1'b0, 1'b0};
    ed = '{default: '0};
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      beat4(1'b0, 16'($urandom));

    // 5x5 frame with gaps.
    n5 = 0;
    for (int i = 0; i < 25; i++) begin
      while ($urandom_range(0, 2) == 0)
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0, 1'b1, i == 0, 16'($urandom));
    end
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("odd_count", 16'(n5), 16'd4);

    // Free-running random traffic on both streams.
    for (int i = 0; i < 1500; i++) begin
      logic va, vb;
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 3) != 0);
      cyc(va, va && ($urandom_range(0, 39) == 0),
          16'($urandom),
          vb, vb && ($urandom_range(0, 59) == 0),
          16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
